// File: rtl/ds_link_pkg.sv
// Shared types and defaults for the DS link exchange-level controller.
// Holds state/mode encodings, credit and timing defaults, error bit indices.
package ds_link_pkg;

    typedef enum logic [2:0] {
        ST_ERR_RESET    = 3'd0,
        ST_WAIT_IN_STOP = 3'd1,
        ST_READY        = 3'd2,
        ST_STARTED      = 3'd3,
        ST_CONNECTING   = 3'd4,
        ST_RUN          = 3'd5
    } link_state_t;

    typedef enum logic [1:0] {
        TX_OFF      = 2'd0,
        TX_NULL     = 2'd1,
        TX_NULL_FCT = 2'd2,
        TX_RUN      = 2'd3
    } tx_mode_t;

    localparam int DEF_T_STOP     = 640;
    localparam int DEF_T_START    = 1280;
    localparam int DEF_FCT_CREDIT = 8;
    localparam int DEF_MAX_CREDIT = 56;
    localparam int TMR_W          = 11;
    localparam int CRED_W         = 7;

    localparam int ERR_PAR    = 0;
    localparam int ERR_ESC    = 1;
    localparam int ERR_DISC   = 2;
    localparam int ERR_CREDIT = 3;

    function automatic tx_mode_t mode_of(link_state_t s);
        tx_mode_t m;
        m = TX_OFF;
        unique case (s)
            ST_STARTED:    m = TX_NULL;
            ST_CONNECTING: m = TX_NULL_FCT;
            ST_RUN:        m = TX_RUN;
            default:       m = TX_OFF;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/ds_link_timer.sv
// Loadable down-counter for state dwell times and timeouts.
// Ports: clk, rst, load, load_val -> value, expired (last counted cycle).
module ds_link_timer
    import ds_link_pkg::*;
#(
    parameter int W       = TMR_W,
    parameter int RST_VAL = DEF_T_STOP
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] value,
    output logic         expired
);

    always_ff @(posedge clk) begin
        if (rst) begin
            value <= W'(RST_VAL);
        end else if (load) begin
            value <= load_val;
        end else if (value != '0) begin
            value <= value - W'(1);
        end
    end

    // A load of N yields exactly N cycles before the owner acts on expiry.
    assign expired = (value == W'(1));

endmodule

// File: rtl/ds_link_ctrl.sv
// Exchange-level controller for one DS link: start-up FSM and credits.
// Ports: link controls, decoder/encoder event pulses -> rx/tx control, state, errors.
module ds_link_ctrl
    import ds_link_pkg::*;
#(
    parameter int T_STOP_CYCLES  = DEF_T_STOP,
    parameter int T_START_CYCLES = DEF_T_START,
    parameter int FCT_CREDIT     = DEF_FCT_CREDIT,
    parameter int MAX_CREDIT     = DEF_MAX_CREDIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       link_start,
    input  logic       link_disable,
    input  logic       auto_start,
    input  logic       err_clr,
    input  logic       rx_got_null,
    input  logic       rx_got_fct,
    input  logic       rx_got_nchar,
    input  logic       rx_err_par,
    input  logic       rx_err_esc,
    input  logic       rx_err_disc,
    input  logic [6:0] rx_fifo_space,
    input  logic       tx_nchar_sent,
    input  logic       tx_fct_ack,
    output logic       rx_enable,
    output logic [1:0] tx_mode,
    output logic       tx_fct_req,
    output logic       tx_credit_ok,
    output logic [2:0] link_state,
    output logic [3:0] err_flags
);

    localparam logic [CRED_W-1:0] FCT  = CRED_W'(FCT_CREDIT);
    localparam logic [CRED_W-1:0] MAXC = CRED_W'(MAX_CREDIT);
    localparam logic [TMR_W-1:0]  TSTP = TMR_W'(T_STOP_CYCLES);
    localparam logic [TMR_W-1:0]  TSTA = TMR_W'(T_START_CYCLES);

    link_state_t       state, nxt;
    logic              null_seen, null_now, null_nxt;
    logic [CRED_W-1:0] tx_credit, tx_nxt, tx_sum;
    logic [CRED_W-1:0] rx_out, rx_nxt, rx_need;
    logic              active, disc_hit, rx_err_any;
    logic              tx_ovf, rx_unf, cred_err, dis_hit;
    logic [3:0]        err_set;
    logic              tmr_load, tmr_exp;
    logic [TMR_W-1:0]  tmr_val, tmr_ld_val;
    logic              req_nxt, ok_nxt;

    ds_link_timer #(
        .W       (TMR_W),
        .RST_VAL (T_STOP_CYCLES)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_ld_val),
        .value    (tmr_val),
        .expired  (tmr_exp)
    );

    always_comb begin
        active     = (state != ST_ERR_RESET);
        null_now   = null_seen | rx_got_null;
        // A disconnect before any NULL is just the line not yet alive.
        disc_hit   = rx_err_disc & null_seen;
        rx_err_any = rx_err_par | rx_err_esc | disc_hit;
        tx_sum     = tx_credit + FCT;
        tx_ovf     = rx_got_fct && (tx_sum > MAXC);
        rx_unf     = rx_got_nchar && (rx_out == '0);
        cred_err   = active && (tx_ovf || rx_unf);
        dis_hit    = link_disable &&
                     !(state inside {ST_ERR_RESET, ST_WAIT_IN_STOP});
        err_set    = '0;
        if (active) begin
            err_set[ERR_PAR]    = rx_err_par;
            err_set[ERR_ESC]    = rx_err_esc;
            err_set[ERR_DISC]   = disc_hit;
            err_set[ERR_CREDIT] = cred_err;
        end

        nxt = state;
        if (active && (rx_err_any || cred_err || dis_hit)) begin
            nxt = ST_ERR_RESET;
        end else begin
            unique case (state)
                ST_ERR_RESET:
                    if (tmr_exp) nxt = ST_WAIT_IN_STOP;
                ST_WAIT_IN_STOP:
                    if (rx_got_fct || rx_got_nchar) nxt = ST_ERR_RESET;
                    else if (tmr_exp) nxt = ST_READY;
                ST_READY:
                    if ((link_start && !link_disable) ||
                        (auto_start && null_now))
                        nxt = ST_STARTED;
                ST_STARTED:
                    if (tmr_exp) nxt = ST_ERR_RESET;
                    else if (null_now) nxt = ST_CONNECTING;
                ST_CONNECTING:
                    if (tmr_exp || rx_got_nchar) nxt = ST_ERR_RESET;
                    else if (rx_got_fct) nxt = ST_RUN;
                ST_RUN:
                    nxt = ST_RUN;
                default:
                    nxt = ST_ERR_RESET;
            endcase
        end

        tx_nxt = tx_credit;
        if (rx_got_fct) tx_nxt = tx_ovf ? MAXC : tx_sum;
        if (tx_nchar_sent && tx_credit != '0) tx_nxt = tx_nxt - 1'b1;

        rx_nxt = rx_out;
        if (tx_fct_ack) rx_nxt = (rx_out > MAXC - FCT) ? MAXC : rx_out + FCT;
        if (rx_got_nchar && rx_out != '0) rx_nxt = rx_nxt - 1'b1;

        null_nxt = null_now;
        if (!active || nxt == ST_ERR_RESET) begin
            tx_nxt   = '0;
            rx_nxt   = '0;
            null_nxt = 1'b0;
        end

        rx_need = rx_nxt + FCT;
        req_nxt = (nxt == ST_CONNECTING || nxt == ST_RUN) &&
                  (rx_need <= MAXC) && (rx_fifo_space >= rx_need);
        ok_nxt  = (nxt == ST_RUN) && (tx_nxt != '0);

        tmr_load   = (nxt != state);
        tmr_ld_val = (nxt == ST_ERR_RESET) ? TSTP : TSTA;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_ERR_RESET;
            null_seen    <= 1'b0;
            tx_credit    <= '0;
            rx_out       <= '0;
            rx_enable    <= 1'b0;
            tx_mode      <= TX_OFF;
            tx_fct_req   <= 1'b0;
            tx_credit_ok <= 1'b0;
            link_state   <= ST_ERR_RESET;
            err_flags    <= '0;
        end else begin
            state        <= nxt;
            null_seen    <= null_nxt;
            tx_credit    <= tx_nxt;
            rx_out       <= rx_nxt;
            rx_enable    <= (nxt != ST_ERR_RESET);
            tx_mode      <= mode_of(nxt);
            tx_fct_req   <= req_nxt;
            tx_credit_ok <= ok_nxt;
            link_state   <= nxt;
            err_flags    <= err_clr ? 4'b0 : (err_flags | err_set);
        end
    end

endmodule

// File: tb/tb_ds_link_ctrl.sv
// Self-checking bench for ds_link_ctrl: start-up timing, credits, errors.
// Table-driven run-phase vectors plus directed multi-cycle sequences.
module tb_ds_link_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       link_start = 0, link_disable = 0, auto_start = 0, err_clr = 0;
    logic       rx_got_null = 0, rx_got_fct = 0, rx_got_nchar = 0;
    logic       rx_err_par = 0, rx_err_esc = 0, rx_err_disc = 0;
    logic [6:0] rx_fifo_space = 7'd64;
    logic       tx_nchar_sent = 0, tx_fct_ack = 0;
    logic       rx_enable, tx_fct_req, tx_credit_ok;
    logic [1:0] tx_mode;
    logic [2:0] link_state;
    logic [3:0] err_flags;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic       start, nul, fct, nchar, ack, sent;
        logic [6:0] space;
        logic [2:0] e_state;
        logic [1:0] e_mode;
        logic       e_req, e_ok;
        logic [3:0] e_err;
    } vec_t;

    vec_t tbl[$];

    ds_link_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .link_start    (link_start),
        .link_disable  (link_disable),
        .auto_start    (auto_start),
        .err_clr       (err_clr),
        .rx_got_null   (rx_got_null),
        .rx_got_fct    (rx_got_fct),
        .rx_got_nchar  (rx_got_nchar),
        .rx_err_par    (rx_err_par),
        .rx_err_esc    (rx_err_esc),
        .rx_err_disc   (rx_err_disc),
        .rx_fifo_space (rx_fifo_space),
        .tx_nchar_sent (tx_nchar_sent),
        .tx_fct_ack    (tx_fct_ack),
        .rx_enable     (rx_enable),
        .tx_mode       (tx_mode),
        .tx_fct_req    (tx_fct_req),
        .tx_credit_ok  (tx_credit_ok),
        .link_state    (link_state),
        .err_flags     (err_flags)
    );

    always #5 clk = ~clk;

    task automatic chk(string nm, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        err_clr       = 0;
        rx_got_null   = 0;
        rx_got_fct    = 0;
        rx_got_nchar  = 0;
        rx_err_par    = 0;
        rx_err_esc    = 0;
        rx_err_disc   = 0;
        tx_nchar_sent = 0;
        tx_fct_ack    = 0;
    endtask

    task automatic ticks(int n);
        repeat (n) tick();
    endtask

    task automatic wait_state(int s, int max, string nm);
        int k;
        k = 0;
        while (link_state != 3'(s) && k < max) begin
            tick();
            k++;
        end
        chk(nm, link_state, s);
    endtask

    function automatic void add(logic st, logic nl, logic fc, logic nc,
                                logic ak, logic se, logic [6:0] sp,
                                logic [2:0] es, logic [1:0] em,
                                logic er, logic eo, logic [3:0] ee);
        vec_t v;
        v.start = st; v.nul = nl; v.fct = fc; v.nchar = nc;
        v.ack = ak; v.sent = se; v.space = sp;
        v.e_state = es; v.e_mode = em; v.e_req = er;
        v.e_ok = eo; v.e_err = ee;
        tbl.push_back(v);
    endfunction

    initial begin
        // Connect and run from STARTED, RX FIFO space fixed at 8.
        add(0, 1, 0, 0, 0, 0, 7'd8, 3'd4, 2'd2, 1, 0, 4'h0);
        add(0, 0, 0, 0, 0, 0, 7'd8, 3'd4, 2'd2, 1, 0, 4'h0);
        add(0, 0, 0, 0, 1, 0, 7'd8, 3'd4, 2'd2, 0, 0, 4'h0);
        add(0, 0, 1, 0, 0, 0, 7'd8, 3'd5, 2'd3, 0, 1, 4'h0);
        for (int k = 0; k < 7; k++)
            add(0, 0, 0, 0, 0, 1, 7'd8, 3'd5, 2'd3, 0, 1, 4'h0);
        add(0, 0, 0, 0, 0, 1, 7'd8, 3'd5, 2'd3, 0, 0, 4'h0);
        add(0, 0, 0, 0, 0, 1, 7'd8, 3'd5, 2'd3, 0, 0, 4'h0);
        for (int k = 0; k < 7; k++)
            add(0, 0, 1, 0, 0, 0, 7'd8, 3'd5, 2'd3, 0, 1, 4'h0);
        add(0, 0, 1, 0, 0, 0, 7'd8, 3'd0, 2'd0, 0, 0, 4'h8);

        ticks(4);
        rst = 0;
        chk("rst state", link_state, 0);
        chk("rst rx_en", rx_enable, 0);
        chk("rst mode", tx_mode, 0);
        chk("rst req", tx_fct_req, 0);
        chk("rst ok", tx_credit_ok, 0);
        chk("rst err", err_flags, 0);

        ticks(639);
        chk("stop dwell end", link_state, 0);
        tick();
        chk("wait entry", link_state, 1);
        chk("wait rx_en", rx_enable, 1);
        ticks(1279);
        chk("wait dwell end", link_state, 1);
        tick();
        chk("ready entry", link_state, 2);

        link_start = 1;
        tick();
        chk("started", link_state, 3);
        chk("started mode", tx_mode, 1);
        link_start = 0;
        ticks(99);
        chk("started hold", link_state, 3);

        for (int i = 0; i < tbl.size(); i++) begin
            link_start    = tbl[i].start;
            rx_fifo_space = tbl[i].space;
            rx_got_null   = tbl[i].nul;
            rx_got_fct    = tbl[i].fct;
            rx_got_nchar  = tbl[i].nchar;
            tx_fct_ack    = tbl[i].ack;
            tx_nchar_sent = tbl[i].sent;
            tick();
            chk($sformatf("row%0d state", i), link_state, tbl[i].e_state);
            chk($sformatf("row%0d mode", i), tx_mode, tbl[i].e_mode);
            chk($sformatf("row%0d req", i), tx_fct_req, tbl[i].e_req);
            chk($sformatf("row%0d ok", i), tx_credit_ok, tbl[i].e_ok);
            chk($sformatf("row%0d err", i), err_flags, tbl[i].e_err);
        end

        err_clr = 1;
        tick();
        chk("clr credit err", err_flags, 0);
        chk("clr in reset", link_state, 0);
        wait_state(2, 2000, "ready again");

        // STARTED without any NULL times out silently.
        link_start = 1;
        tick();
        chk("started2", link_state, 3);
        link_start = 0;
        ticks(1279);
        chk("started2 hold", link_state, 3);
        tick();
        chk("start timeout", link_state, 0);
        chk("timeout err", err_flags, 0);
        chk("timeout mode", tx_mode, 0);

        wait_state(2, 2000, "ready third");
        rx_err_disc = 1;
        tick();
        chk("disc ignored", link_state, 2);
        chk("disc no flag", err_flags, 0);

        rx_fifo_space = 7'd64;
        link_start = 1;
        tick();
        chk("started3", link_state, 3);
        link_start = 0;
        rx_got_null = 1;
        tick();
        chk("connecting3", link_state, 4);
        chk("conn req", tx_fct_req, 1);
        tx_fct_ack = 1;
        tick();
        rx_got_fct = 1;
        tick();
        chk("run3", link_state, 5);
        chk("run3 ok", tx_credit_ok, 1);
        rx_fifo_space = 7'd10;
        tick();
        chk("space10 out8 req", tx_fct_req, 0);
        for (int k = 0; k < 3; k++) begin
            rx_got_nchar = 1;
            tick();
        end
        chk("out5 space10 req", tx_fct_req, 0);
        chk("out5 still run", link_state, 5);
        rx_fifo_space = 7'd13;
        tick();
        chk("out5 space13 req", tx_fct_req, 1);
        rx_fifo_space = 7'd12;
        tick();
        chk("out5 space12 req", tx_fct_req, 0);

        rx_err_par = 1;
        tick();
        chk("par state", link_state, 0);
        chk("par err", err_flags, 1);
        chk("par mode", tx_mode, 0);
        chk("par rx_en", rx_enable, 0);
        ticks(639);
        chk("par dwell", link_state, 0);
        tick();
        chk("par wait", link_state, 1);
        err_clr = 1;
        tick();
        chk("par clr", err_flags, 0);

        rx_err_esc = 1;
        err_clr = 1;
        tick();
        chk("esc state", link_state, 0);
        chk("clr beats set", err_flags, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
